// File: rtl/show_number.sv
// show_number: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A free-running refresh counter's top two bits select the active digit.
// Digit enable and segment pattern are registered together so they never disagree.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module show_number #(
  parameter int unsigned DIV_WIDTH = 18
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] number0,
  input  logic [3:0] number1,
  input  logic [3:0] number2,
  input  logic [3:0] number3,
  output logic [7:0] ss_out,
  output logic [3:0] ss_digit
);

  localparam int unsigned SEL_WIDTH = 2;
  localparam int unsigned SEG_WIDTH = 8;
  localparam int unsigned DIG_WIDTH = 4;

  localparam logic [SEG_WIDTH-1:0] SEG_DARK = 8'hFF;
  localparam logic [DIG_WIDTH-1:0] DIG_OFF  = 4'b1111;

  logic [DIV_WIDTH-1:0] refresh_cnt;
  logic [DIV_WIDTH-1:0] refresh_cnt_nxt;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEG_WIDTH-1:0] ss_out_nxt;
  logic [DIG_WIDTH-1:0] ss_digit_nxt;
  logic                 blank1;
  logic                 blank2;
  logic                 blank3;

  // Hex to active-low segment pattern, dp off; unknown input stays dark.
  function automatic logic [SEG_WIDTH-1:0] decode(input logic [3:0] value);
    logic [SEG_WIDTH-1:0] seg;
    seg = SEG_DARK;
    case (value)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_DARK;
    endcase
    return seg;
  endfunction

  assign sel = refresh_cnt[DIV_WIDTH-1 -: SEL_WIDTH];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and every digit to its left are zero.
  always_comb begin
    blank3 = (number3 == 4'h0);
    blank2 = blank3 && (number2 == 4'h0);
    blank1 = blank2 && (number1 == 4'h0);
  end
`else
  // Every digit is always decoded.
  always_comb begin
    blank3 = 1'b0;
    blank2 = 1'b0;
    blank1 = 1'b0;
  end
`endif

  // Next counter value and next digit/segment pair for the current slot.
  always_comb begin
    refresh_cnt_nxt = refresh_cnt + DIV_WIDTH'(1);
    ss_digit_nxt    = DIG_OFF;
    ss_out_nxt      = SEG_DARK;
    case (sel)
      2'd0: begin
        ss_digit_nxt = 4'b1110;
        ss_out_nxt   = decode(number0);
      end
      2'd1: begin
        ss_digit_nxt = 4'b1101;
        ss_out_nxt   = blank1 ? SEG_DARK : decode(number1);
      end
      2'd2: begin
        ss_digit_nxt = 4'b1011;
        ss_out_nxt   = blank2 ? SEG_DARK : decode(number2);
      end
      2'd3: begin
        ss_digit_nxt = 4'b0111;
        ss_out_nxt   = blank3 ? SEG_DARK : decode(number3);
      end
      default: begin
        ss_digit_nxt = DIG_OFF;
        ss_out_nxt   = SEG_DARK;
      end
    endcase
  end

  // Refresh counter and registered display outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      ss_digit    <= DIG_OFF;
      ss_out      <= SEG_DARK;
    end else begin
      refresh_cnt <= refresh_cnt_nxt;
      ss_digit    <= ss_digit_nxt;
      ss_out      <= ss_out_nxt;
    end
  end

endmodule

// File: tb/tb_show_number.sv
// tb_show_number: randomized bench for show_number with an in-bench reference model.
// Define LEADING_ZERO_BLANK_EN for both files to exercise leading-zero blanking.
module tb_show_number;

  localparam int unsigned W     = 4;
  localparam int unsigned SLOT  = 1 << (W - 2);
  localparam int unsigned CYCLE = 1 << W;

  logic       clock;
  logic       reset_n;
  logic [3:0] number0, number1, number2, number3;
  logic [7:0] ss_out;
  logic [3:0] ss_digit;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  logic [7:0] exp_seg;
  logic [3:0] exp_digit;
  int unsigned m_cnt;

  logic [7:0] seg_table [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  show_number #(.DIV_WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .number0  (number0),
    .number1  (number1),
    .number2  (number2),
    .number3  (number3),
    .ss_out   (ss_out),
    .ss_digit (ss_digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: elapsed clocks since reset pick the slot; values come from the table.
  always @(posedge clock or negedge reset_n) begin
    logic [3:0] nums [4];
    int unsigned s;
    bit blank;
    if (!reset_n) begin
      m_cnt     = 0;
      exp_digit = 4'b1111;
      exp_seg   = 8'hFF;
    end else begin
      nums[0] = number0; nums[1] = number1; nums[2] = number2; nums[3] = number3;
      s = m_cnt / SLOT;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (s != 0) begin
        blank = 1'b1;
        for (int j = int'(s); j < 4; j++)
          if (nums[j] != 4'h0) blank = 1'b0;
      end
`endif
      exp_digit = 4'b1111 & ~(4'b0001 << s);
      exp_seg   = blank ? 8'hFF : seg_table[nums[s]];
      m_cnt     = (m_cnt + 1) % CYCLE;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("model_digit", {4'h0, ss_digit}, {4'h0, exp_digit});
      chk("model_seg", ss_out, exp_seg);
    end
  end

  task automatic set_nums(input logic [3:0] n3, input logic [3:0] n2,
                          input logic [3:0] n1, input logic [3:0] n0);
    number3 = n3; number2 = n2; number1 = n1; number0 = n0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Bounded search for a given digit enable; expiry counts as a failure.
  task automatic find_digit(input logic [3:0] d, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      #1;
      if (ss_digit == d) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL find_digit actual=%b required=%b (timeout)", ss_digit, d);
    end
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    set_nums(4'h0, 4'h0, 4'h0, 4'h0);

    // Reset held while clocking.
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("reset_digit", {4'h0, ss_digit}, 8'h0F);
    chk("reset_seg", ss_out, 8'hFF);

    // Scan sequence 2,4,8,A with literal expectations per slot and wrap.
    set_nums(4'hA, 4'h8, 4'h4, 4'h2);
    check_en = 1'b1;
    release_reset();
    wait_edges(1);
    chk("scan0_digit", {4'h0, ss_digit}, 8'h0E);
    chk("scan0_seg", ss_out, 8'hA4);
    wait_edges(4);
    chk("scan1_digit", {4'h0, ss_digit}, 8'h0D);
    chk("scan1_seg", ss_out, 8'h99);
    wait_edges(4);
    chk("scan2_digit", {4'h0, ss_digit}, 8'h0B);
    chk("scan2_seg", ss_out, 8'h80);
    wait_edges(4);
    chk("scan3_digit", {4'h0, ss_digit}, 8'h07);
    chk("scan3_seg", ss_out, 8'h88);
    wait_edges(3);
    chk("scan3_last_seg", ss_out, 8'h88);
    wait_edges(1);
    chk("wrap_digit", {4'h0, ss_digit}, 8'h0E);
    chk("wrap_seg", ss_out, 8'hA4);

    // Live update of number1 inside its slot.
    wait_edges(4);
    chk("live_before", ss_out, 8'h99);
    number1 = 4'hF;
    wait_edges(1);
    chk("live_after", ss_out, 8'h8E);
    chk("live_digit", {4'h0, ss_digit}, 8'h0D);

    // Decode sweep: each value on all digits for a full scan.
    for (int v = 0; v < 16; v++) begin
      set_nums(4'(v), 4'(v), 4'(v), 4'(v));
      wait_edges(CYCLE);
    end

    // Leading zeros: 0,0,0,7.
    set_nums(4'h0, 4'h0, 4'h0, 4'h7);
    wait_edges(1);
    find_digit(4'b1110, found);
    if (found) chk("lz_digit0", ss_out, 8'hF8);
    find_digit(4'b0111, found);
`ifdef LEADING_ZERO_BLANK_EN
    if (found) chk("lz_digit3", ss_out, 8'hFF);
`else
    if (found) chk("lz_digit3", ss_out, 8'hC0);
`endif
    set_nums(4'h0, 4'h0, 4'h0, 4'h0);
    wait_edges(1);
    find_digit(4'b1101, found);
`ifdef LEADING_ZERO_BLANK_EN
    if (found) chk("zero_digit1", ss_out, 8'hFF);
`else
    if (found) chk("zero_digit1", ss_out, 8'hC0);
`endif
    find_digit(4'b1110, found);
    if (found) chk("zero_digit0", ss_out, 8'hC0);

    // Randomized inputs, biased toward zeros to reach blanking cases.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        number0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        number1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        number2 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        number3 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
    end

    // Asynchronous reset mid-scan: outputs go dark with no clock edge.
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_digit", {4'h0, ss_digit}, 8'h0F);
    chk("async_rst_seg", ss_out, 8'hFF);
    wait_edges(2);
    set_nums(4'h1, 4'h2, 4'h3, 4'h5);
    release_reset();
    wait_edges(1);
    chk("restart_digit", {4'h0, ss_digit}, 8'h0E);
    chk("restart_seg", ss_out, 8'h92);

    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if ($urandom_range(0, 7) == 0)
        set_nums(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
